fp_normalize_round: RTL and testbench
=====================================

FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANT_WIDTH, default 23, stored fraction width.
REQ-003 SHALL have parameter IN_WIDTH, default MANT_WIDTH+5, raw significand width.
- Raw significand weights: bit IN_WIDTH-1 = 2^1, bit IN_WIDTH-2 = 2^0.
REQ-004 SHALL have clk, input, 1, sole clock; all state on its rising edge.
REQ-005 SHALL have rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have in_valid, input, 1, upstream operand valid.
REQ-007 SHALL have in_ready, output, 1, block can accept an operand.
REQ-008 SHALL have in_sign, input, 1, result sign.
REQ-009 SHALL have in_exp, input, EXP_WIDTH+2, signed two's-complement biased exponent of weight 2^0.
REQ-010 SHALL have in_mant, input, IN_WIDTH, unnormalized magnitude.
REQ-011 SHALL have out_valid, output, 1, result valid.
REQ-012 SHALL have out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have out_result, output, 1+EXP_WIDTH+MANT_WIDTH, packed {sign, exp, frac}.
REQ-014 SHALL have out_flags, output, 3, {overflow, underflow, inexact}.

Function
REQ-015 SHALL be a two-stage valid/ready pipeline: S1 (leading-one detect, shift, exponent adjust) and S2 (round, pack).
- Each stage register loads when it is empty or its contents leave in the same cycle.
REQ-016 SHALL assert in_ready = !S1_valid | S1 advances; a transfer occurs only on in_valid & in_ready.
REQ-017 SHALL present the result with out_valid high on the 2nd rising edge after acceptance when out_ready stays high.
- Sustained throughput: one result per cycle.
REQ-018 SHALL hold out_result, out_flags and out_valid stable while out_valid & !out_ready.
- Full pipeline under backpressure holds exactly 2 operands; in_ready low; no operand lost or duplicated.
REQ-019 SHALL, in S1, find p, the highest set bit of in_mant:
- p = IN_WIDTH-1: shift right 1; shifted-out bit ORs into sticky.
- Otherwise: shift left by IN_WIDTH-2-p.
- Exponent e = in_exp + p - (IN_WIDTH-2), computed in EXP_WIDTH+3 signed bits without wrap.
REQ-020 SHALL, in S2, round to nearest, ties to even, at the normalized significand bits:
- Hidden bit IN_WIDTH-2; fraction = next MANT_WIDTH bits; guard = next bit; sticky = OR of all lower bits.
REQ-021 SHALL, on rounding carry-out, set the fraction to 0 and increment e.
REQ-022 SHALL set inexact when guard | sticky is 1.
REQ-023 SHALL, when the final e >= 2^EXP_WIDTH-1, output signed infinity (exp all ones, frac 0) and set overflow and inexact.
REQ-024 SHALL, when the final e <= 0 and the magnitude is nonzero, output signed zero (no subnormals) and set underflow and inexact.
REQ-025 SHALL, when in_mant = 0, output signed zero with all flags 0.
REQ-026 SHALL evaluate overflow and underflow on the post-rounding exponent.

Reset
REQ-027 SHALL, while rst_n is low, immediately clear S1_valid, S2_valid and out_valid.
- out_result and out_flags read 0 during reset.
REQ-028 SHALL drive in_ready high in the first cycle after rst_n deasserts.
REQ-029 SHALL discard in-flight operands when reset asserts mid-operation; no stale result appears after release.

Verification
REQ-030 Bench SHALL cover these cases (EXP_WIDTH=8, MANT_WIDTH=23, IN_WIDTH=28, out_ready high unless noted):
- 1.0: in_mant=28'h4000000, in_exp=127, in_sign=0 -> out_result=32'h3F800000, flags 0, two cycles after acceptance.
- Right-normalize and left-normalize: in_mant=28'h8000000, in_exp=127 -> 32'h40000000. in_mant=28'h0000010, in_exp=149 -> 32'h3F800000.
- Tie round-up with carry: in_mant=28'h7FFFFFC, in_exp=127 -> 32'h40000000, inexact=1. Same with in_exp=254 -> 32'h7F800000, flags 3'b101.
- Zero and underflow: in_mant=0, in_sign=1 -> 32'h80000000, flags 0. in_mant=28'h4000000, in_exp=0 -> 32'h00000000, flags 3'b011.
- Backpressure: stream 4 operands back-to-back with out_ready held low 5 cycles. in_ready drops after 2 accepts; outputs stay stable; all 4 results emerge in order once out_ready rises.
- Reset mid-flight: assert rst_n low with 2 operands in flight -> out_valid low within the same cycle; no result appears after release; in_ready=1.

Source files
------------

// File: rtl/fp_normalize_round.sv
// Two-stage floating-point normalize (S1) and round-to-nearest-even/pack (S2)
// pipeline with valid/ready handshaking; results flush to zero instead of going subnormal.
module fp_normalize_round #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int IN_WIDTH   = MANT_WIDTH + 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_sign,
  input  logic [EXP_WIDTH+1:0]              in_exp,
  input  logic [IN_WIDTH-1:0]               in_mant,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0]     out_result,
  output logic [2:0]                        out_flags
);

  localparam int EW    = EXP_WIDTH + 3;
  localparam int FW    = IN_WIDTH - 2;
  localparam int LOW_W = IN_WIDTH - MANT_WIDTH - 3;
  localparam int PW    = $clog2(IN_WIDTH);

  logic                          s1Valid_q, s1Sign_q, s1Sticky_q, s1Zero_q;
  logic signed [EW-1:0]          s1Exp_q;
  logic [FW-1:0]                 s1Frac_q;
  logic                          outValid_q;
  logic [EXP_WIDTH+MANT_WIDTH:0] result_q, result_d;
  logic [2:0]                    flags_q, flags_d;

  logic                          s2Free, inFire;
  logic [PW-1:0]                 lead;
  logic [FW-1:0]                 norm_d;
  logic                          sticky_d;
  logic signed [EW-1:0]          exp_d;

  assign s2Free   = !outValid_q | out_ready;
  assign in_ready = !s1Valid_q | s2Free;
  assign inFire   = in_valid & in_ready;

  always_comb begin
    lead = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (in_mant[i]) lead = PW'(i);
    end
  end

  // Only the bits below the hidden one are kept; the hidden bit is 1 for every nonzero input.
  always_comb begin
    sticky_d = 1'b0;
    if (lead == PW'(IN_WIDTH - 1)) begin
      norm_d   = in_mant[IN_WIDTH-2:1];
      sticky_d = in_mant[0];
    end else begin
      norm_d = FW'(in_mant << (PW'(IN_WIDTH - 2) - lead));
    end
    exp_d = {{(EW-EXP_WIDTH-2){in_exp[EXP_WIDTH+1]}}, in_exp}
          + {{(EW-PW){1'b0}}, lead} - EW'(IN_WIDTH - 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Sign_q   <= 1'b0;
      s1Sticky_q <= 1'b0;
      s1Zero_q   <= 1'b0;
      s1Exp_q    <= '0;
      s1Frac_q   <= '0;
    end else if (inFire) begin
      s1Valid_q  <= 1'b1;
      s1Sign_q   <= in_sign;
      s1Sticky_q <= sticky_d;
      s1Zero_q   <= (in_mant == '0);
      s1Exp_q    <= exp_d;
      s1Frac_q   <= norm_d;
    end else if (s2Free) begin
      s1Valid_q  <= 1'b0;
    end
  end

  logic [MANT_WIDTH-1:0] frac;
  logic                  guard, stickyAll, roundUp, carry, overflow, underflow, inexact;
  logic [MANT_WIDTH-1:0] fracR;
  logic [EW-1:0]         expR;

  assign frac      = s1Frac_q[FW-1 -: MANT_WIDTH];
  assign guard     = s1Frac_q[LOW_W];
  assign stickyAll = (|s1Frac_q[LOW_W-1:0]) | s1Sticky_q;
  assign roundUp   = guard & (stickyAll | frac[0]);
  // A fraction carry-out means the significand reached 2.0; the fraction wraps to zero.
  assign {carry, fracR} = {1'b0, frac} + {{MANT_WIDTH{1'b0}}, roundUp};
  assign expR      = s1Exp_q + {{(EW-1){1'b0}}, carry};
  assign overflow  = !expR[EW-1] && (expR[EW-2:0] >= (EW-1)'((1 << EXP_WIDTH) - 1));
  assign underflow = expR[EW-1] || (expR == '0);
  assign inexact   = guard | stickyAll;

  always_comb begin
    result_d = '0;
    flags_d  = 3'b000;
    if (s1Zero_q) begin
      result_d = {s1Sign_q, {(EXP_WIDTH+MANT_WIDTH){1'b0}}};
    end else if (overflow) begin
      result_d = {s1Sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      flags_d  = 3'b101;
    end else if (underflow) begin
      result_d = {s1Sign_q, {(EXP_WIDTH+MANT_WIDTH){1'b0}}};
      flags_d  = 3'b011;
    end else begin
      result_d = {s1Sign_q, expR[EXP_WIDTH-1:0], fracR};
      flags_d  = {2'b00, inexact};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else if (s2Free) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid  = outValid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round: directed table, backpressure and
// reset corner sequences, then randomized traffic against an arithmetic reference model.
module tb_fp_normalize_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [27:0] mant;
    logic [31:0] result;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic [2:0]  flags;
  } exp_t;

  exp_t expQ[$];

  fp_normalize_round #(.EXP_WIDTH(8), .MANT_WIDTH(23), .IN_WIDTH(28)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Value-level reference: scale the magnitude to 24 significant bits with
  // integer shifts, round half-to-even on the remainder, then classify the exponent.
  function automatic exp_t model(input logic s, input logic signed [9:0] e, input logic [27:0] m);
    exp_t   r;
    longint mm, q, rem, half;
    int     p, sh, ex;
    bit     inexact;
    r.result = {s, 31'b0};
    r.flags  = 3'b000;
    if (m == 28'd0) return r;
    mm = longint'(m);
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    sh = p - 23;
    inexact = 1'b0;
    if (sh > 0) begin
      q    = mm >> sh;
      rem  = mm & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      inexact = (rem != 0);
    end else begin
      q = mm << (-sh);
    end
    ex = int'(e) + p - 26;
    if (q == (64'sd1 << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) begin
      r.result = {s, 8'hFF, 23'd0};
      r.flags  = 3'b101;
    end else if (ex <= 0) begin
      r.result = {s, 31'd0};
      r.flags  = 3'b011;
    end else begin
      r.result = {s, ex[7:0], q[22:0]};
      r.flags  = {2'b00, inexact};
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One handshake cycle: drive at the falling edge, then score what the next rising edge will transfer.
  task automatic applyStimulus(input logic v, input logic s, input logic [9:0] e, input logic [27:0] m,
                               input logic r, output logic acc, output logic got);
    @(negedge clk);
    in_valid  = v;
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    out_ready = r;
    #1;
    acc = in_valid & in_ready;
    got = 1'b0;
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected out_valid", out_valid, 0);
      end else if (out_ready) begin
        checkOutput("result", out_result, expQ[0].result);
        checkOutput("flags", out_flags, expQ[0].flags);
        void'(expQ.pop_front());
        got = 1'b1;
      end else begin
        checkOutput("held result", out_result, expQ[0].result);
        checkOutput("held flags", out_flags, expQ[0].flags);
      end
    end
    if (acc) expQ.push_back(model(s, e, m));
  endtask

  task automatic runVector(input vec_t v, input int idx);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sign   = v.sign;
    in_exp    = v.exp;
    in_mant   = v.mant;
    out_ready = 1'b1;
    #1 checkOutput($sformatf("vec%0d in_ready", idx), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 checkOutput($sformatf("vec%0d early out_valid", idx), out_valid, 0);
    @(negedge clk);
    #1;
    checkOutput($sformatf("vec%0d out_valid", idx), out_valid, 1);
    checkOutput($sformatf("vec%0d result", idx), out_result, v.result);
    checkOutput($sformatf("vec%0d flags", idx), out_flags, v.flags);
  endtask

  vec_t        vecs[7];
  logic [27:0] bpMant[4];
  logic [9:0]  bpExp[4];

  initial begin
    logic acc, got;
    int   sent, recv, guardCnt;

    vecs[0] = '{1'b0, 10'd127, 28'h4000000, 32'h3F800000, 3'b000};
    vecs[1] = '{1'b0, 10'd127, 28'h8000000, 32'h40000000, 3'b000};
    vecs[2] = '{1'b0, 10'd149, 28'h0000010, 32'h3F800000, 3'b000};
    vecs[3] = '{1'b0, 10'd127, 28'h7FFFFFC, 32'h40000000, 3'b001};
    vecs[4] = '{1'b0, 10'd254, 28'h7FFFFFC, 32'h7F800000, 3'b101};
    vecs[5] = '{1'b1, 10'd5,   28'h0000000, 32'h80000000, 3'b000};
    vecs[6] = '{1'b0, 10'd0,   28'h4000000, 32'h00000000, 3'b011};

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_result", out_result, 0);
    checkOutput("reset out_flags", out_flags, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("post-reset in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) runVector(vecs[i], i);

    // Backpressure: four back-to-back operands while the sink stalls for five cycles.
    for (int i = 0; i < 4; i++) begin
      bpMant[i] = 28'h4000000;
      bpExp[i]  = 10'(127 + i);
    end
    sent = 0;
    recv = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(sent < 4, 1'b0, bpExp[sent % 4], bpMant[sent % 4], 1'b0, acc, got);
      if (acc) sent++;
      if (c >= 2) checkOutput("bp in_ready low", in_ready, 0);
    end
    checkOutput("bp accepts while stalled", sent, 2);
    guardCnt = 0;
    while ((sent < 4 || expQ.size() > 0) && guardCnt < 30) begin
      applyStimulus(sent < 4, 1'b0, bpExp[sent % 4], bpMant[sent % 4], 1'b1, acc, got);
      if (acc) sent++;
      if (got) recv++;
      guardCnt++;
    end
    checkOutput("bp results delivered", recv, 4);

    // Reset with two operands in flight.
    applyStimulus(1'b1, 1'b0, 10'd130, 28'h5000000, 1'b0, acc, got);
    applyStimulus(1'b1, 1'b1, 10'd131, 28'h6000000, 1'b0, acc, got);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset out_result", out_result, 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("midreset in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 28'd0, 1'b1, acc, got);
      checkOutput("stale out_valid", out_valid, 0);
    end

    // Randomized traffic with random stalls on both sides.
    for (int c = 0; c < 1500; c++) begin
      logic        v, r, s;
      logic [27:0] m;
      int          w, ei;
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      s  = 1'($urandom);
      ei = int'($urandom_range(0, 560)) - 50;
      w  = $urandom_range(1, 28);
      m  = 28'($urandom);
      if (w < 28) m = m & ((28'd1 << w) - 28'd1);
      if ($urandom_range(0, 7) == 0) m = {m[27:3], 3'b100};
      if ($urandom_range(0, 15) == 0) m = 28'd0;
      applyStimulus(v, s, 10'(ei), m, r, acc, got);
    end
    guardCnt = 0;
    while (expQ.size() > 0 && guardCnt < 10) begin
      applyStimulus(1'b0, 1'b0, 10'd0, 28'd0, 1'b1, acc, got);
      guardCnt++;
    end
    checkOutput("random drain", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
